instruction_fetch: RTL

Pipeline stage 1 of the MIPS core: holds the program counter, owns the word-addressed instruction memory, and drives the IF/ID pipeline register that feeds `instruction_decode`. It advances the PC sequentially and accepts stall and branch/jump redirects from later stages. It detects a HALT word, and exposes a write port so the debug unit can load a program before execution.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instruction_memory.sv | 32 +++
 rtl/instruction_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and types: instruction encodings, PC increment,
// the IF/ID register layout and the fetch-stage next-PC selector.
package mips_pkg;

  localparam int NB_DATA = 32;

  localparam logic [NB_DATA-1:0] INSTR_NOP  = '0;
  localparam logic [NB_DATA-1:0] INSTR_HALT = '1;
  localparam logic [NB_DATA-1:0] PC_INC     = NB_DATA'(4);

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_HALT,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  typedef struct packed {
    logic [NB_DATA-1:0] instr;
    logic [NB_DATA-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous write port for the debug
// loader, combinational read port for fetch. Byte offset and upper bits ignored.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int NB_DATA   = mips_pkg::NB_DATA,
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               we,
  input  logic [NB_DATA-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_DATA-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  // NOTE: the array has no reset, so a program loaded before a core reset survives it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW+1:2]] <= wdata;
  end

  assign rdata = mem[raddr[AW+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr[NB_DATA-1:AW+2], waddr[1:0],
                              raddr[NB_DATA-1:AW+2], raddr[1:0]};

endmodule

// File: rtl/instruction_fetch.sv
// MIPS pipeline stage 1: program counter, next-PC selection, HALT detection
// and the IF/ID register feeding instruction_decode.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                      NB_DATA   = mips_pkg::NB_DATA,
  parameter int                      MEM_DEPTH = 256,
  parameter logic [NB_DATA-1:0]      RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_branch,
  input  logic [NB_DATA-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_target,
  input  logic               i_prog_we,
  input  logic [NB_DATA-1:0] i_prog_addr,
  input  logic [NB_DATA-1:0] i_prog_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt
);

  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] mem_rdata;
  logic               halt;
  if_id_t             if_id;
  pc_sel_e            pc_sel;

  instruction_memory #(
    .NB_DATA  (NB_DATA),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .we   (i_prog_we),
    .waddr(i_prog_addr),
    .wdata(i_prog_data),
    .raddr(pc),
    .rdata(mem_rdata)
  );

  assign pc_plus4 = pc + PC_INC;

  // A redirect outranks a stall: the stalled instruction is on the wrong path anyway.
  always_comb begin
    // NOTE: default first so every path assigns pc_sel and no latch is inferred.
    pc_sel = SEL_SEQ;
    if (i_prog_we || !i_enable) pc_sel = SEL_HOLD;
    else if (halt)              pc_sel = SEL_HALT;
    else if (i_jump)            pc_sel = SEL_JUMP;
    else if (i_branch)          pc_sel = SEL_BRANCH;
    else if (i_stall)           pc_sel = SEL_HOLD;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc    <= RESET_PC;
      if_id <= '0;
      halt  <= 1'b0;
    end else begin
      case (pc_sel)
        SEL_HALT: if_id <= '{instr: INSTR_NOP, pc4: '0};
        SEL_JUMP: begin
          pc    <= i_jump_target;
          if_id <= '{instr: INSTR_NOP, pc4: '0};
        end
        SEL_BRANCH: begin
          pc    <= i_branch_target;
          if_id <= '{instr: INSTR_NOP, pc4: '0};
        end
        SEL_SEQ: begin
          if_id <= '{instr: mem_rdata, pc4: pc_plus4};
          // The PC parks on the HALT word so o_pc reports where execution stopped.
          if (mem_rdata == INSTR_HALT) halt <= 1'b1;
          else                         pc   <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  assign o_instruction = i_prog_we ? INSTR_NOP : if_id.instr;
  assign o_pcounter4   = if_id.pc4;
  assign o_pc          = pc;
  assign o_halt        = halt;

endmodule
